// File: rtl/data_memory_responder.sv
// Load/store responder: word RAM with WAIT_CYCLES wait states, byte/half/word lanes, sign/zero extension.
// Optional misalignment fault when DMEM_ALIGN_CHECK_EN is defined; otherwise sub-word addresses are force-aligned.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        fault_o
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   off_d;
  logic          in_range_d;
  logic [AW-1:0] idx_d;
  logic [31:0]   cur_word_d;
  logic [31:0]   wr_word_d;
  logic [31:0]   ld_val_d;
  logic [7:0]    ld_byte_d;
  logic [15:0]   ld_half_d;
  logic          misalign_d;
  logic          access_d;
  logic          wr_en_d;

  assign off_d      = addr_q - BASE_ADDR;
  assign in_range_d = off_d < 32'(DEPTH_WORDS * 4);
  assign idx_d      = off_d[AW+1:2];
  assign cur_word_d = mem_q[idx_d];
  assign access_d   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign wr_en_d    = access_d && we_q && in_range_d && !misalign_d;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_d = ((size_q == 2'b01) && off_d[0]) ||
                      (size_q[1] && (off_d[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  // Lane merge for stores: unselected bytes keep the current RAM contents.
  always_comb begin
    wr_word_d = cur_word_d;
    unique case (size_q)
      2'b00: begin
        unique case (off_d[1:0])
          2'd0: wr_word_d[7:0]   = wdata_q[7:0];
          2'd1: wr_word_d[15:8]  = wdata_q[7:0];
          2'd2: wr_word_d[23:16] = wdata_q[7:0];
          default: wr_word_d[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (off_d[1]) wr_word_d[31:16] = wdata_q[15:0];
        else          wr_word_d[15:0]  = wdata_q[15:0];
      end
      default: wr_word_d = wdata_q;
    endcase
  end

  always_comb begin
    unique case (off_d[1:0])
      2'd0: ld_byte_d = cur_word_d[7:0];
      2'd1: ld_byte_d = cur_word_d[15:8];
      2'd2: ld_byte_d = cur_word_d[23:16];
      default: ld_byte_d = cur_word_d[31:24];
    endcase
    ld_half_d = off_d[1] ? cur_word_d[31:16] : cur_word_d[15:0];
    unique case (size_q)
      2'b00:   ld_val_d = sext_q ? {{24{ld_byte_d[7]}}, ld_byte_d} : {24'd0, ld_byte_d};
      2'b01:   ld_val_d = sext_q ? {{16{ld_half_d[15]}}, ld_half_d} : {16'd0, ld_half_d};
      default: ld_val_d = cur_word_d;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            size_q  <= size_i;
            sext_q  <= sext_i;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            fault_q <= misalign_d;
            if (!we_q) rdata_q <= (misalign_d || !in_range_d) ? 32'd0 : ld_val_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Writes happen only on the WAIT->DONE edge, so a reset during WAIT never commits a store.
  always_ff @(posedge clk_i) begin
    if (wr_en_d) mem_q[idx_d] <= wr_word_d;
  end

  assign stall_o = !reset_i && (((state_q == S_IDLE) && req_i) || (state_q == S_WAIT));
  assign rdata_o = rdata_q;
  assign done_o  = done_q;
  assign fault_o = fault_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_memory_responder;
  localparam logic [31:0] BASE = 32'h10010000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we, sext;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        stall0, done0, fault0, stall1, done1, fault1;
  logic [31:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut0 (
    .clk_i(clk), .reset_i(reset), .req_i(req0), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .size_i(size), .sext_i(sext), .stall_o(stall0), .rdata_o(rdata0), .done_o(done0), .fault_o(fault0)
  );

  data_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut1 (
    .clk_i(clk), .reset_i(reset), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .size_i(size), .sext_i(sext), .stall_o(stall1), .rdata_o(rdata1), .done_o(done1), .fault_o(fault1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request, held while stalled; returns stall cycle count and the DONE-cycle outputs.
  task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic sx,
                        output int stalls, output logic [31:0] rd, output logic flt);
    logic got;
    got = 1'b0; stalls = 0; rd = '0; flt = 1'b0;
    @(negedge clk);
    we = w; addr = a; wdata = d; size = sz; sext = sx;
    if (sel == 0) req0 = 1'b1; else req1 = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if ((sel == 0) ? done0 : done1) begin
        got = 1'b1;
        rd  = (sel == 0) ? rdata0 : rdata1;
        flt = (sel == 0) ? fault0 : fault1;
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        if ((sel == 0) ? stall0 : stall1) stalls++;
        @(negedge clk);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int st;
    logic [31:0] rd;
    logic fl;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we = 1'b0; sext = 1'b0;
    addr = '0; wdata = '0; size = 2'b10;
    #12;
    check("rst_stall", {31'd0, stall0}, 32'd0);
    check("rst_done",  {31'd0, done0},  32'd0);
    check("rst_fault", {31'd0, fault0}, 32'd0);
    check("rst_rdata", rdata0, 32'd0);
    @(negedge clk); reset = 1'b0;

    // 1: word store / load timing
    access(0, 1'b1, BASE, 32'hDEADBEEF, 2'b10, 1'b0, st, rd, fl);
    check("t1_sw_stall", st, 4);
    check("t1_sw_fault", {31'd0, fl}, 32'd0);
    @(negedge clk); #1;
    check("t1_done_pulse", {31'd0, done0}, 32'd0);
    access(0, 1'b0, BASE, 32'h0, 2'b10, 1'b0, st, rd, fl);
    check("t1_lw", rd, 32'hDEADBEEF);

    // 2: byte store and sub-word loads
    access(0, 1'b1, BASE + 3, 32'hAAAAAA80, 2'b00, 1'b0, st, rd, fl);
    access(0, 1'b0, BASE + 3, 32'h0, 2'b00, 1'b1, st, rd, fl);
    check("t2_lb", rd, 32'hFFFFFF80);
    access(0, 1'b0, BASE + 3, 32'h0, 2'b00, 1'b0, st, rd, fl);
    check("t2_lbu", rd, 32'h00000080);
    access(0, 1'b0, BASE, 32'h0, 2'b10, 1'b1, st, rd, fl);
    check("t2_lw", rd, 32'h80ADBEEF);

    // 3: half loads; a store keeps rdata; half store lane merge
    access(0, 1'b0, BASE + 2, 32'h0, 2'b01, 1'b1, st, rd, fl);
    check("t3_lh", rd, 32'hFFFF80AD);
    access(0, 1'b0, BASE + 2, 32'h0, 2'b01, 1'b0, st, rd, fl);
    check("t3_lhu", rd, 32'h000080AD);
    access(0, 1'b1, BASE + 8, 32'h11112222, 2'b10, 1'b0, st, rd, fl);
    check("t3_rdata_hold", rd, 32'h000080AD);
    access(0, 1'b1, BASE + 8, 32'hBBBB1234, 2'b01, 1'b0, st, rd, fl);
    access(0, 1'b0, BASE + 8, 32'h0, 2'b10, 1'b0, st, rd, fl);
    check("t3_sh_merge", rd, 32'h11111234);

    // 4: out of range store/load, no aliasing onto word 0
    access(0, 1'b1, BASE + 32'h1000, 32'h12345678, 2'b10, 1'b0, st, rd, fl);
    check("t4_oor_stall", st, 4);
    access(0, 1'b0, BASE + 32'h1000, 32'h0, 2'b10, 1'b0, st, rd, fl);
    check("t4_oor_lw", rd, 32'h0);
    access(0, 1'b0, BASE, 32'h0, 2'b10, 1'b0, st, rd, fl);
    check("t4_no_alias", rd, 32'h80ADBEEF);

    // 5: reset during WAIT abandons the store
    @(negedge clk);
    we = 1'b1; addr = BASE; wdata = 32'h0; size = 2'b10; req0 = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check("t5_stall_wait", {31'd0, stall0}, 32'd1);
    reset = 1'b1; req0 = 1'b0; #1;
    check("t5_rst_stall", {31'd0, stall0}, 32'd0);
    check("t5_rst_done",  {31'd0, done0},  32'd0);
    check("t5_rst_rdata", rdata0, 32'd0);
    @(negedge clk); reset = 1'b0;
    access(0, 1'b0, BASE, 32'h0, 2'b10, 1'b0, st, rd, fl);
    check("t5_lw_kept", rd, 32'h80ADBEEF);

    // 6: misaligned accesses
    access(0, 1'b0, BASE + 2, 32'h0, 2'b10, 1'b0, st, rd, fl);
    check("t6_lw_mis_stall", st, 4);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t6_lw_mis_rdata", rd, 32'h0);
    check("t6_lw_mis_fault", {31'd0, fl}, 32'd1);
`else
    check("t6_lw_mis_rdata", rd, 32'h80ADBEEF);
    check("t6_lw_mis_fault", {31'd0, fl}, 32'd0);
`endif
    access(0, 1'b0, BASE + 1, 32'h0, 2'b01, 1'b0, st, rd, fl);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t6_lhu_mis", rd, 32'h0);
`else
    check("t6_lhu_mis", rd, 32'h0000BEEF);
`endif
    access(0, 1'b1, BASE + 1, 32'h55555555, 2'b10, 1'b0, st, rd, fl);
    access(0, 1'b0, BASE, 32'h0, 2'b10, 1'b0, st, rd, fl);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t6_sw_mis_dropped", rd, 32'h80ADBEEF);
`else
    check("t6_sw_mis_aligned", rd, 32'h55555555);
`endif

    // 6b: zero wait states
    access(1, 1'b1, BASE, 32'hCAFEF00D, 2'b10, 1'b0, st, rd, fl);
    check("t6b_sw_stall", st, 2);
    access(1, 1'b0, BASE + 2, 32'h0, 2'b10, 1'b0, st, rd, fl);
    check("t6b_lw_stall", st, 2);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t6b_lw_mis_rdata", rd, 32'h0);
    check("t6b_lw_mis_fault", {31'd0, fl}, 32'd1);
`else
    check("t6b_lw_mis_rdata", rd, 32'hCAFEF00D);
    check("t6b_lw_mis_fault", {31'd0, fl}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
